seq_divider: RTL



---
 rtl/milano_pkg.sv | 15 +
 rtl/seq_divider.sv | 129 ++++++++++++
 2 files changed

// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the multiply/divide unit
package milano_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH   = 32;
  // Cycles from the start-sampling edge through the done cycle, for requester stall logic
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider with RISC-V M-extension semantics
module seq_divider
  import milano_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic             div_kill_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             div_busy_o,
  output logic             div_done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             fast_q;

  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   trial;

  assign div_zero     = (divisor_i == '0);
  assign overflow     = div_signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
  assign dividend_mag = (div_signed_i && dividend_i[WIDTH-1]) ? negate(dividend_i) : dividend_i;
  assign divisor_mag  = (div_signed_i && divisor_i[WIDTH-1])  ? negate(divisor_i)  : divisor_i;

  // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (div_start_i) begin
          state_d = (div_zero || overflow) ? FIXUP : CALC;
        end
      end
      CALC:    if (cnt_q == '0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_kill_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      fast_q      <= 1'b0;
      div_busy_o  <= 1'b0;
      div_done_o  <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      state_q    <= state_d;
      div_busy_o <= (state_d != IDLE);
      div_done_o <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (div_start_i) begin
            neg_quo_q <= div_signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem_q <= div_signed_i && dividend_i[WIDTH-1];
            dvsr_q    <= divisor_mag;
            cnt_q     <= CNT_W'(WIDTH - 1);
            if (div_zero) begin
              fast_q <= 1'b1;
              quo_q  <= '1;
              rem_q  <= dividend_i;
            end else if (overflow) begin
              fast_q <= 1'b1;
              quo_q  <= dividend_i;
              rem_q  <= '0;
            end else begin
              fast_q <= 1'b0;
              quo_q  <= dividend_mag;
              rem_q  <= '0;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          end
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIXUP: begin
          // A flush here must leave the previously published result intact
          if (!div_kill_i) begin
            quotient_o  <= (!fast_q && neg_quo_q) ? negate(quo_q) : quo_q;
            remainder_o <= (!fast_q && neg_rem_q) ? negate(rem_q) : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
